// File: rtl/sram_port_arbiter_pkg.sv
// Shared constants for the fetch/load-store SRAM port arbiter.
package sram_port_arbiter_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned WEN_W   = 4;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned OWNER_W = 2;

    // Default number of consecutive lost cycles before fetch is forced through.
    localparam int unsigned STARVE_MAX_DEFAULT = 4;

    // Tag of the read whose data returns next cycle.
    localparam logic [OWNER_W-1:0] OWNER_NONE      = 2'd0;
    localparam logic [OWNER_W-1:0] OWNER_INST      = 2'd1;
    localparam logic [OWNER_W-1:0] OWNER_DATA      = 2'd2;
    localparam logic [OWNER_W-1:0] OWNER_INST_DROP = 2'd3;

    // Fetch addresses are word addresses; the byte offset never reaches the SRAM.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/sram_port_arbiter_arb_rsp_hold.sv
// Read-data hold register: passes live data on the response cycle, else the last delivered word.
module arb_rsp_hold
    import sram_port_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              capture,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q_out
);

    logic [DATA_W-1:0] held;

    // Keep the most recently delivered word.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            held <= '0;
        end else if (capture) begin
            held <= d;
        end
    end

    // Live data on the response cycle, held word otherwise.
    assign q_out = capture ? d : held;

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-ported SRAM between fetch and load/store with data priority,
// starvation relief for fetch and cancellation of in-flight fetch reads.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_cancel,
    output logic              inst_grant,
    output logic              inst_rvalid,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic [WEN_W-1:0]  data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_grant,
    output logic              data_rvalid,
    output logic [DATA_W-1:0] data_rdata,
    output logic              sram_en,
    output logic [WEN_W-1:0]  sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    logic               starved_c;
    logic               inst_win_c;
    logic               data_win_c;
    logic [CNT_W-1:0]   starve_cnt;
    logic [CNT_W-1:0]   starve_cnt_next;
    logic [OWNER_W-1:0] owner;
    logic [OWNER_W-1:0] owner_next;

    // Same-cycle arbitration; nothing is granted while reset is asserted.
    always_comb begin
        starved_c  = (starve_cnt == CNT_W'(STARVE_MAX));
        inst_win_c = resetn && inst_req && (!data_req || starved_c);
        data_win_c = resetn && data_req && !inst_win_c;
    end

    assign inst_grant = inst_win_c;
    assign data_grant = data_win_c;

    // Winner drives the SRAM port; fetch is always a word read.
    always_comb begin
        sram_en    = 1'b0;
        sram_wen   = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (inst_win_c) begin
            sram_en   = 1'b1;
            sram_addr = word_align(inst_addr);
        end else if (data_win_c) begin
            sram_en    = 1'b1;
            sram_wen   = data_wen;
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
        end
    end

    // Next owner tag and starvation count from this cycle's grant.
    always_comb begin
        owner_next      = OWNER_NONE;
        starve_cnt_next = '0;
        if (inst_win_c) begin
            owner_next = inst_cancel ? OWNER_INST_DROP : OWNER_INST;
        end else if (data_win_c && (data_wen == '0)) begin
            owner_next = OWNER_DATA;
        end
        if (inst_req && !inst_win_c) begin
            starve_cnt_next = starved_c ? starve_cnt : starve_cnt + CNT_W'(1);
        end
    end

    // Owner tag and starvation counter state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner      <= OWNER_NONE;
            starve_cnt <= '0;
        end else begin
            owner      <= owner_next;
            starve_cnt <= starve_cnt_next;
        end
    end

    // A late cancel turns an INST response into a dropped one.
    assign inst_rvalid = (owner == OWNER_INST) && !inst_cancel;
    assign data_rvalid = (owner == OWNER_DATA);

    arb_rsp_hold u_inst_hold (
        .clk     (clk),
        .resetn  (resetn),
        .capture (inst_rvalid),
        .d       (sram_rdata),
        .q_out   (inst_rdata)
    );

    arb_rsp_hold u_data_hold (
        .clk     (clk),
        .resetn  (resetn),
        .capture (data_rvalid),
        .d       (sram_rdata),
        .q_out   (data_rdata)
    );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: arbitration, starvation, cancel, writes, reset.
module tb_sram_port_arbiter;

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_cancel;
    logic        inst_grant;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_grant;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    int tests;
    int fails;

    sram_port_arbiter #(.STARVE_MAX(4)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_cancel (inst_cancel),
        .inst_grant  (inst_grant),
        .inst_rvalid (inst_rvalid),
        .inst_rdata  (inst_rdata),
        .data_req    (data_req),
        .data_wen    (data_wen),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_grant  (data_grant),
        .data_rvalid (data_rvalid),
        .data_rdata  (data_rdata),
        .sram_en     (sram_en),
        .sram_wen    (sram_wen),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        inst_req    = 1'b0;
        inst_addr   = '0;
        inst_cancel = 1'b0;
        data_req    = 1'b0;
        data_wen    = '0;
        data_addr   = '0;
        data_wdata  = '0;
    endtask

    task automatic test_reset;
        resetn      = 1'b0;
        inst_req    = 1'b1;
        inst_addr   = $urandom;
        inst_cancel = 1'b0;
        data_req    = 1'b1;
        data_wen    = 4'hf;
        data_addr   = $urandom;
        data_wdata  = $urandom;
        sram_rdata  = 32'h5a5a5a5a;
        step;
        step;
        #2;
        tests++;
        if ({inst_grant, data_grant, inst_rvalid, data_rvalid, sram_en, sram_wen} !== 9'd0) begin
            fails++;
            $display("FAIL reset_ctrl got %b required 0", {inst_grant, data_grant, inst_rvalid, data_rvalid, sram_en, sram_wen});
        end
        tests++;
        if ({sram_addr, sram_wdata, inst_rdata, data_rdata} !== 128'd0) begin
            fails++;
            $display("FAIL reset_data got %h %h %h %h required 0", sram_addr, sram_wdata, inst_rdata, data_rdata);
        end
        step;
        idle_inputs();
        resetn = 1'b1;
        step;
        inst_req  = 1'b1;
        inst_addr = 32'hbfc00003;
        #2;
        tests++;
        if (inst_grant !== 1'b1 || sram_addr !== 32'hbfc00000 || sram_en !== 1'b1 || sram_wen !== 4'h0) begin
            fails++;
            $display("FAIL first_fetch_grant got grant=%b addr=%h en=%b wen=%h required 1 bfc00000 1 0", inst_grant, sram_addr, sram_en, sram_wen);
        end
        step;
        inst_req   = 1'b0;
        sram_rdata = 32'h3c1d0000;
        #2;
        tests++;
        if (inst_rvalid !== 1'b1 || inst_rdata !== 32'h3c1d0000) begin
            fails++;
            $display("FAIL first_fetch_rsp got rvalid=%b rdata=%h required 1 3c1d0000", inst_rvalid, inst_rdata);
        end
        step;
        sram_rdata = 32'hdeadbeef;
        step;
        #2;
        tests++;
        if (inst_rvalid !== 1'b0 || inst_rdata !== 32'h3c1d0000) begin
            fails++;
            $display("FAIL first_fetch_hold got rvalid=%b rdata=%h required 0 3c1d0000", inst_rvalid, inst_rdata);
        end
    endtask

    task automatic test_data_priority;
        step;
        data_req  = 1'b1;
        data_wen  = 4'h0;
        data_addr = 32'h80001000;
        inst_req  = 1'b1;
        inst_addr = 32'h00400000;
        #2;
        tests++;
        if (data_grant !== 1'b1 || inst_grant !== 1'b0 || sram_addr !== 32'h80001000) begin
            fails++;
            $display("FAIL prio_grant got d=%b i=%b addr=%h required 1 0 80001000", data_grant, inst_grant, sram_addr);
        end
        step;
        data_req   = 1'b0;
        sram_rdata = 32'h11112222;
        #2;
        tests++;
        if (data_rvalid !== 1'b1 || data_rdata !== 32'h11112222 || inst_grant !== 1'b1 || sram_addr !== 32'h00400000) begin
            fails++;
            $display("FAIL prio_rsp got dv=%b dd=%h ig=%b addr=%h required 1 11112222 1 00400000", data_rvalid, data_rdata, inst_grant, sram_addr);
        end
        step;
        inst_req   = 1'b0;
        sram_rdata = 32'h33334444;
        #2;
        tests++;
        if (inst_rvalid !== 1'b1 || inst_rdata !== 32'h33334444 || data_rvalid !== 1'b0 || data_rdata !== 32'h11112222) begin
            fails++;
            $display("FAIL prio_inst_rsp got iv=%b id=%h dv=%b dd=%h required 1 33334444 0 11112222", inst_rvalid, inst_rdata, data_rvalid, data_rdata);
        end
        step;
        idle_inputs();
    endtask

    task automatic test_starvation;
        step;
        data_req  = 1'b1;
        data_wen  = 4'h0;
        data_addr = 32'h80002000;
        inst_req  = 1'b1;
        inst_addr = 32'h00400010;
        for (int c = 1; c <= 4; c++) begin
            #2;
            tests++;
            if (data_grant !== 1'b1 || inst_grant !== 1'b0) begin
                fails++;
                $display("FAIL starve_lost_%0d got d=%b i=%b required 1 0", c, data_grant, inst_grant);
            end
            step;
        end
        #2;
        tests++;
        if (inst_grant !== 1'b1 || data_grant !== 1'b0 || sram_addr !== 32'h00400010) begin
            fails++;
            $display("FAIL starve_win got i=%b d=%b addr=%h required 1 0 00400010", inst_grant, data_grant, sram_addr);
        end
        step;
        inst_addr = 32'h00400014;
        #2;
        tests++;
        if (data_grant !== 1'b1 || inst_grant !== 1'b0) begin
            fails++;
            $display("FAIL starve_cleared got d=%b i=%b required 1 0", data_grant, inst_grant);
        end
        step;
        idle_inputs();
        step;
        step;
    endtask

    task automatic test_cancel;
        inst_req  = 1'b1;
        inst_addr = 32'h00000100;
        step;
        inst_req   = 1'b0;
        sram_rdata = 32'haaaa0001;
        #2;
        tests++;
        if (inst_rvalid !== 1'b1 || inst_rdata !== 32'haaaa0001) begin
            fails++;
            $display("FAIL cancel_setup got rvalid=%b rdata=%h required 1 aaaa0001", inst_rvalid, inst_rdata);
        end
        step;
        inst_req  = 1'b1;
        inst_addr = 32'h00000104;
        step;
        inst_req    = 1'b0;
        inst_cancel = 1'b1;
        sram_rdata  = 32'hbbbb0002;
        #2;
        tests++;
        if (inst_rvalid !== 1'b0 || inst_rdata !== 32'haaaa0001) begin
            fails++;
            $display("FAIL cancel_late got rvalid=%b rdata=%h required 0 aaaa0001", inst_rvalid, inst_rdata);
        end
        step;
        inst_cancel = 1'b0;
        #2;
        tests++;
        if (inst_rvalid !== 1'b0 || inst_rdata !== 32'haaaa0001) begin
            fails++;
            $display("FAIL cancel_late_after got rvalid=%b rdata=%h required 0 aaaa0001", inst_rvalid, inst_rdata);
        end
        step;
        inst_req    = 1'b1;
        inst_addr   = 32'h00000108;
        inst_cancel = 1'b1;
        #2;
        tests++;
        if (inst_grant !== 1'b1) begin
            fails++;
            $display("FAIL cancel_early_grant got %b required 1", inst_grant);
        end
        step;
        inst_req    = 1'b0;
        inst_cancel = 1'b0;
        sram_rdata  = 32'hcccc0003;
        #2;
        tests++;
        if (inst_rvalid !== 1'b0 || inst_rdata !== 32'haaaa0001) begin
            fails++;
            $display("FAIL cancel_early got rvalid=%b rdata=%h required 0 aaaa0001", inst_rvalid, inst_rdata);
        end
        data_req  = 1'b1;
        data_wen  = 4'h0;
        data_addr = 32'h80003000;
        step;
        data_req    = 1'b0;
        inst_cancel = 1'b1;
        sram_rdata  = 32'hdddd0005;
        #2;
        tests++;
        if (data_rvalid !== 1'b1 || data_rdata !== 32'hdddd0005) begin
            fails++;
            $display("FAIL cancel_data_unaffected got rvalid=%b rdata=%h required 1 dddd0005", data_rvalid, data_rdata);
        end
        step;
        idle_inputs();
    endtask

    task automatic test_write;
        step;
        data_req   = 1'b1;
        data_wen   = 4'b0011;
        data_addr  = 32'h80000010;
        data_wdata = 32'h1234abcd;
        #2;
        tests++;
        if (data_grant !== 1'b1 || sram_en !== 1'b1 || sram_wen !== 4'b0011 || sram_addr !== 32'h80000010 || sram_wdata !== 32'h1234abcd) begin
            fails++;
            $display("FAIL write_drive got g=%b en=%b wen=%b addr=%h wd=%h required 1 1 0011 80000010 1234abcd", data_grant, sram_en, sram_wen, sram_addr, sram_wdata);
        end
        step;
        data_wen   = 4'b0000;
        data_wdata = 32'h0;
        sram_rdata = 32'heeee0006;
        #2;
        tests++;
        if (data_rvalid !== 1'b0 || data_grant !== 1'b1 || sram_wen !== 4'b0000) begin
            fails++;
            $display("FAIL write_no_rsp got dv=%b g=%b wen=%b required 0 1 0000", data_rvalid, data_grant, sram_wen);
        end
        step;
        data_req   = 1'b0;
        inst_req   = 1'b1;
        inst_addr  = 32'h00000200;
        sram_rdata = 32'h1234abcd;
        #2;
        tests++;
        if (data_rvalid !== 1'b1 || data_rdata !== 32'h1234abcd || inst_grant !== 1'b1) begin
            fails++;
            $display("FAIL write_load_back got dv=%b dd=%h ig=%b required 1 1234abcd 1", data_rvalid, data_rdata, inst_grant);
        end
        step;
        inst_req   = 1'b0;
        sram_rdata = 32'h0f0f0f0f;
        #2;
        tests++;
        if (inst_rvalid !== 1'b1 || inst_rdata !== 32'h0f0f0f0f || data_rdata !== 32'h1234abcd) begin
            fails++;
            $display("FAIL back_to_back_rsp got iv=%b id=%h dd=%h required 1 0f0f0f0f 1234abcd", inst_rvalid, inst_rdata, data_rdata);
        end
        tests++;
        if (sram_en !== 1'b0 || sram_addr !== 32'h0 || sram_wdata !== 32'h0 || sram_wen !== 4'h0) begin
            fails++;
            $display("FAIL idle_port got en=%b addr=%h wd=%h wen=%h required 0 0 0 0", sram_en, sram_addr, sram_wdata, sram_wen);
        end
        step;
    endtask

    task automatic test_reset_mid_read;
        inst_req  = 1'b1;
        inst_addr = 32'h00000300;
        #2;
        tests++;
        if (inst_grant !== 1'b1) begin
            fails++;
            $display("FAIL midrst_grant got %b required 1", inst_grant);
        end
        step;
        inst_req   = 1'b0;
        resetn     = 1'b0;
        sram_rdata = 32'h77770007;
        #2;
        tests++;
        if (inst_rvalid !== 1'b0 || inst_rdata !== 32'h0) begin
            fails++;
            $display("FAIL midrst_during got rvalid=%b rdata=%h required 0 0", inst_rvalid, inst_rdata);
        end
        step;
        resetn = 1'b1;
        #2;
        tests++;
        if (inst_rvalid !== 1'b0 || data_rvalid !== 1'b0 || inst_rdata !== 32'h0) begin
            fails++;
            $display("FAIL midrst_release got iv=%b dv=%b id=%h required 0 0 0", inst_rvalid, data_rvalid, inst_rdata);
        end
        step;
        #2;
        tests++;
        if (inst_rvalid !== 1'b0 || data_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL midrst_after got iv=%b dv=%b required 0 0", inst_rvalid, data_rvalid);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        sram_rdata = '0;
        test_reset();
        test_data_priority();
        test_starvation();
        test_cancel();
        test_write();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
